proc_mem_arbiter: RTL and testbench

- Shares one single-ported memory between the pipelined TinyRV1 core's instruction-fetch port (imem) and data port (dmem).
- Arbitrates requests with val/rdy handshakes, keeps exactly one transaction outstanding, and routes each response back to the requester that issued it.
- Dmem has priority by default, and a starvation counter guarantees fetch progress.
- Sits between the processor (datapath plus control) and the memory model.

---
 rtl/proc_mem_arbiter_if.sv | 49 ++++
 rtl/proc_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_proc_mem_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/proc_mem_arbiter_if.sv
// proc_mem_arbiter_if
//   Bundles the three val/rdy buses around the arbiter: the processor
//   fetch port (imem*), the processor data port (dmem*), and the shared
//   single-ported memory (mem*).
//   modport slave  : the arbiter's view. It receives the imem/dmem
//                    requests and the memory responses. It drives the
//                    memory requests and the imem/dmem responses.
//   modport master : the environment's view (processor plus memory model).
interface proc_mem_arbiter_if;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_data;

  logic        dmemreq_val;
  logic        dmemreq_rdy;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic        dmemresp_val;
  logic [31:0] dmemresp_data;

  logic        memreq_val;
  logic        memreq_rdy;
  logic        memreq_type;
  logic [31:0] memreq_addr;
  logic [31:0] memreq_wdata;
  logic        memresp_val;
  logic [31:0] memresp_data;

  modport slave (
    input  imemreq_val, imemreq_addr,
    output imemreq_rdy, imemresp_val, imemresp_data,
    input  dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
    output dmemreq_rdy, dmemresp_val, dmemresp_data,
    output memreq_val, memreq_type, memreq_addr, memreq_wdata,
    input  memreq_rdy, memresp_val, memresp_data
  );

  modport master (
    output imemreq_val, imemreq_addr,
    input  imemreq_rdy, imemresp_val, imemresp_data,
    output dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
    input  dmemreq_rdy, dmemresp_val, dmemresp_data,
    input  memreq_val, memreq_type, memreq_addr, memreq_wdata,
    output memreq_rdy, memresp_val, memresp_data
  );
endinterface

// File: rtl/proc_mem_arbiter.sv
// proc_mem_arbiter
//   Shares one single-ported memory between the core's fetch port (imem)
//   and data port (dmem). Only one transaction is outstanding at a time.
//   The data port wins by default. After STARVE_LIMIT consecutive dmem
//   grants taken while a fetch was waiting, the fetch gets one forced grant.
//   Ports:
//     clk  - clock
//     rst  - synchronous, active-low reset
//     bus  - proc_mem_arbiter_if.slave (imem, dmem and memory buses)
module proc_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  proc_mem_arbiter_if.slave     bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;

  state_t     state_reg, state_next;
  logic       owner_reg, owner_next;      // 1 = dmem owns the transaction
  logic [3:0] starve_reg, starve_next;

  logic        sel_dmem;
  logic        req_active;
  logic        req_val;
  logic        req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        irdy, drdy;
  logic        iresp_val, dresp_val;
  logic        fire;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      owner_reg  <= 1'b0;
      starve_reg <= 4'd0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      starve_reg <= starve_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    starve_next = starve_reg;
    sel_dmem    = owner_reg;
    req_active  = 1'b0;
    req_val     = 1'b0;
    req_type    = 1'b0;
    req_addr    = 32'd0;
    req_wdata   = 32'd0;
    irdy        = 1'b0;
    drdy        = 1'b0;
    iresp_val   = 1'b0;
    dresp_val   = 1'b0;
    fire        = 1'b0;

    // While in reset every handshake output stays low.
    if (rst) begin
      case (state_reg)
        IDLE: begin
          if (bus.imemreq_val || bus.dmemreq_val) begin
            // Forced fetch grant only when the counter has saturated.
            sel_dmem   = bus.dmemreq_val &&
                         !((starve_reg == LIMIT) && bus.imemreq_val);
            req_active = 1'b1;
            req_val    = 1'b1;
            owner_next = sel_dmem;
            state_next = bus.memreq_rdy ? WAIT : HOLD;
          end
        end
        HOLD: begin
          // Locked to the owner; a later higher-priority arrival waits.
          sel_dmem   = owner_reg;
          req_active = 1'b1;
          req_val    = owner_reg ? bus.dmemreq_val : bus.imemreq_val;
          if (req_val && bus.memreq_rdy) state_next = WAIT;
        end
        WAIT: begin
          // Responses seen in IDLE/HOLD are spurious and ignored by
          // construction, since only this state forwards them.
          if (bus.memresp_val) begin
            iresp_val  = !owner_reg;
            dresp_val  = owner_reg;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase

      if (req_active) begin
        if (sel_dmem) begin
          req_type  = bus.dmemreq_type;
          req_addr  = bus.dmemreq_addr;
          req_wdata = bus.dmemreq_wdata;
          drdy      = bus.memreq_rdy;
        end else begin
          req_addr  = bus.imemreq_addr;
          irdy      = bus.memreq_rdy;
        end
      end

      fire = req_val && bus.memreq_rdy;
      if (fire) begin
        if (sel_dmem && bus.imemreq_val)
          starve_next = (starve_reg >= LIMIT) ? LIMIT : starve_reg + 4'd1;
        else
          starve_next = 4'd0;
      end
    end
  end

  assign bus.memreq_val    = req_val;
  assign bus.memreq_type   = req_type;
  assign bus.memreq_addr   = req_addr;
  assign bus.memreq_wdata  = req_wdata;
  assign bus.imemreq_rdy   = irdy;
  assign bus.dmemreq_rdy   = drdy;
  assign bus.imemresp_val  = iresp_val;
  assign bus.dmemresp_val  = dresp_val;
  // Data is a pass-through; the val bits qualify it.
  assign bus.imemresp_data = bus.memresp_data;
  assign bus.dmemresp_data = bus.memresp_data;

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// tb_proc_mem_arbiter
//   Directed bench for proc_mem_arbiter: reset behaviour, single fetch,
//   imem/dmem conflict, backpressure hold, starvation grant order and
//   reset during an outstanding transaction.
module tb_proc_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  proc_mem_arbiter_if bus_if();

  proc_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive shortly after the edge, sample on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia,
                       input logic dv, input logic dt, input logic [31:0] da,
                       input logic [31:0] dw, input logic mr, input logic mv,
                       input logic [31:0] md);
    bus_if.imemreq_val   = iv;
    bus_if.imemreq_addr  = ia;
    bus_if.dmemreq_val   = dv;
    bus_if.dmemreq_type  = dt;
    bus_if.dmemreq_addr  = da;
    bus_if.dmemreq_wdata = dw;
    bus_if.memreq_rdy    = mr;
    bus_if.memresp_val   = mv;
    bus_if.memresp_data  = md;
  endtask

  function automatic logic [4:0] hs();
    return {bus_if.memreq_val, bus_if.imemreq_rdy, bus_if.dmemreq_rdy,
            bus_if.imemresp_val, bus_if.dmemresp_val};
  endfunction

  initial begin
    string order;
    logic  exp_d;
    order = "DDDDIDDDDI";

    // 1. reset with everything asserted
    drive(1, 32'h200, 1, 0, 32'h300, 0, 1, 1, 32'h99);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("rst_outputs", 32'(hs()), 32'b00000);
      cyc();
    end
    rst = 1'b1;
    drive(1, 32'h200, 1, 0, 32'h300, 0, 1, 0, 0);
    settle();
    check("post_rst_grant", 32'(hs()), 32'b10100);
    check("post_rst_addr", bus_if.memreq_addr, 32'h300);
    $display("txn: first grant dmem addr=%h", bus_if.memreq_addr);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h11);
    settle();
    check("post_rst_resp", 32'(hs()), 32'b00001);
    check("post_rst_rdata", bus_if.dmemresp_data, 32'h11);
    cyc();

    // 2. single fetch, response 3 cycles later
    drive(1, 32'h200, 0, 0, 0, 0, 1, 0, 0);
    settle();
    check("fetch_hs", 32'(hs()), 32'b11000);
    check("fetch_addr", bus_if.memreq_addr, 32'h200);
    check("fetch_type", 32'(bus_if.memreq_type), 32'd0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    settle();
    check("fetch_wait", 32'(hs()), 32'b00000);
    cyc();
    cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF);
    settle();
    check("fetch_resp", 32'(hs()), 32'b00010);
    check("fetch_rdata", bus_if.imemresp_data, 32'hDEADBEEF);
    $display("txn: fetch 0x200 -> %h", bus_if.imemresp_data);
    cyc();

    // 3. conflict: dmem write wins, then the fetch
    drive(1, 32'h200, 1, 1, 32'h1000, 32'h5, 1, 0, 0);
    settle();
    check("conf_hs", 32'(hs()), 32'b10100);
    check("conf_type", 32'(bus_if.memreq_type), 32'd1);
    check("conf_addr", bus_if.memreq_addr, 32'h1000);
    check("conf_wdata", bus_if.memreq_wdata, 32'h5);
    $display("txn: dmem write 0x1000 = %h", bus_if.memreq_wdata);
    cyc();
    drive(1, 32'h200, 0, 0, 0, 0, 1, 0, 0);
    settle();
    check("conf_wait", 32'(hs()), 32'b00000);
    cyc();
    drive(1, 32'h200, 0, 0, 0, 0, 1, 1, 32'h0);
    settle();
    check("conf_dresp", 32'(hs()), 32'b00001);
    cyc();
    drive(1, 32'h200, 0, 0, 0, 0, 1, 0, 0);
    settle();
    check("conf_ifire", 32'(hs()), 32'b11000);
    check("conf_iaddr", bus_if.memreq_addr, 32'h200);
    $display("txn: fetch 0x200 after dmem");
    cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 32'hCAFE);
    settle();
    check("conf_iresp", 32'(hs()), 32'b00010);
    check("conf_irdata", bus_if.imemresp_data, 32'hCAFE);
    cyc();

    // 4. backpressure: fetch held, dmem arrives late and must not preempt
    drive(1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("bp_hs0", 32'(hs()), 32'b10000);
    check("bp_addr0", bus_if.memreq_addr, 32'h200);
    for (int i = 1; i < 3; i++) begin
      cyc();
      drive(1, 32'h200, 1, 0, 32'h1000, 0, 0, 0, 0);
      settle();
      check("bp_hs", 32'(hs()), 32'b10000);
      check("bp_addr", bus_if.memreq_addr, 32'h200);
    end
    // a response while holding is spurious
    bus_if.memresp_val = 1'b1;
    settle();
    #1;
    check("bp_spurious", 32'(hs()), 32'b10000);
    cyc();
    drive(1, 32'h200, 1, 0, 32'h1000, 0, 1, 0, 0);
    settle();
    check("bp_release", 32'(hs()), 32'b11000);
    check("bp_raddr", bus_if.memreq_addr, 32'h200);
    $display("txn: held fetch 0x200 released");
    cyc();
    drive(0, 0, 1, 0, 32'h1000, 0, 1, 1, 32'h77);
    settle();
    check("bp_iresp", 32'(hs()), 32'b00010);
    cyc();
    drive(0, 0, 1, 0, 32'h1000, 0, 1, 0, 0);
    settle();
    check("bp_dfire", 32'(hs()), 32'b10100);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h88);
    settle();
    check("bp_dresp", 32'(hs()), 32'b00001);
    cyc();

    // 5. starvation: both always valid, 1-cycle memory
    for (int t = 0; t < 10; t++) begin
      exp_d = (order[t] == "D");
      drive(1, 32'h200, 1, 0, 32'h1000, 0, 1, 0, 0);
      settle();
      check($sformatf("starve_grant%0d", t), 32'(hs()),
            exp_d ? 32'b10100 : 32'b11000);
      $display("txn: starve slot %0d grant=%s", t,
               bus_if.dmemreq_rdy ? "D" : (bus_if.imemreq_rdy ? "I" : "-"));
      cyc();
      drive(1, 32'h200, 1, 0, 32'h1000, 0, 1, 1, 32'(t));
      settle();
      check($sformatf("starve_resp%0d", t), 32'(hs()),
            exp_d ? 32'b00001 : 32'b00010);
      cyc();
    end

    // 6. reset while waiting drops the late response
    drive(0, 0, 1, 0, 32'h40, 0, 1, 0, 0);
    settle();
    check("rw_fire", 32'(hs()), 32'b10100);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    rst = 1'b0;
    settle();
    check("rw_inrst", 32'(hs()), 32'b00000);
    cyc();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h1234);
    settle();
    check("rw_dropped", 32'(hs()), 32'b00000);
    cyc();
    drive(1, 32'h500, 0, 0, 0, 0, 1, 0, 0);
    settle();
    check("rw_ifire", 32'(hs()), 32'b11000);
    check("rw_iaddr", bus_if.memreq_addr, 32'h500);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h5555);
    settle();
    check("rw_iresp", 32'(hs()), 32'b00010);
    check("rw_irdata", bus_if.imemresp_data, 32'h5555);
    $display("txn: fetch 0x500 after reset -> %h", bus_if.imemresp_data);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
